sm_addr_alloc: RTL
==================

# sm_addr_alloc

Free-address allocator and round-robin arbiter for the shared cache memory of the switch. It keeps the pool of free buffer addresses in a circular free list, grants at most one address per cycle to one of `PORT_NUB_TOTAL` ingress ports, and takes back addresses released by the egress side. It sits between the ingress write logic and the shared memory units, and it owns the address space of the shared buffer.

## Interface
- `PORT_NUB_TOTAL`, default `` `PORT_NUB_TOTAL `` (8): number of requesting ports.
- `DEPTH`, default 64: number of shared-buffer addresses. Must be a power of 2 and ≥ 2.
- `ADDR_WIDTH`, derived as `$clog2(DEPTH)`: address width.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `req` input PORT_NUB_TOTAL: per-port allocation request, level, sampled every cycle.
- `grant` output PORT_NUB_TOTAL: one-hot grant, registered.
- `alloc_valid` output 1: `alloc_addr` is valid this cycle. Equals `|grant`.
- `alloc_addr` output ADDR_WIDTH: the allocated address.
- `rel_valid` input 1: return the address on `rel_addr` to the pool.
- `rel_addr` input ADDR_WIDTH: the address being released.
- `ready` output 1: initialisation is complete.
- `free_cnt` output ADDR_WIDTH+1: number of free addresses.
- `rel_err` output 1: sticky flag for a release received while the pool was full.

## Operation
- Internal state: free-list RAM of DEPTH×ADDR_WIDTH, `head`, `tail`, `free_cnt`, `rr_ptr`, and the FSM {INIT, RUN}.
- Reset (`rst_n`=0 at a rising edge):
  - state=INIT, init counter=0, head=tail=0, `free_cnt`=0, `rr_ptr`=0.
  - All outputs are 0.
- INIT:
  - Each cycle writes `list[cnt]=cnt`, then increments `cnt` and `free_cnt`.
  - After DEPTH writes: tail=0 (wrapped), `free_cnt`=DEPTH, state→RUN, `ready`=1.
  - `req` and `rel_valid` are ignored during INIT, and no grants are issued.
- RUN, arbitration:
  - When `free_cnt`>0 and `req`≠0, the winner is the first set `req[i]` scanning i = `rr_ptr`, `rr_ptr`+1, … modulo PORT_NUB_TOTAL.
  - At the next edge: `grant`=onehot(winner), `alloc_addr`=`list[head]`, head+1 modulo DEPTH, `rr_ptr`=(winner+1) modulo PORT_NUB_TOTAL.
  - With no winner: `grant`=0, `alloc_valid`=0, and `rr_ptr` holds.
- Requests:
  - A port that wants exactly one address drops `req` combinationally in the cycle its `grant` is high.
  - A `req` still high in that cycle counts as a new request.
- RUN, release:
  - With `rel_valid`=1 and `free_cnt`<DEPTH: `list[tail]`=`rel_addr`, tail+1 modulo DEPTH.
  - With `free_cnt`=DEPTH: the release is dropped, `rel_err` is set to 1, and `rel_err` stays 1 until reset.
- `free_cnt` next value = `free_cnt` − alloc + release_accepted. A simultaneous alloc and release leaves it unchanged.
- No bypass: with `free_cnt`=0, an address released in cycle t can be granted at the earliest from a request sampled in cycle t+1.
- Addresses are not checked for duplicates. Uniqueness is the releaser's responsibility.
- Reset asserted mid-INIT or mid-RUN restarts INIT from 0. All pool contents are discarded.

## Timing
- INIT lasts exactly DEPTH cycles. `ready` rises at the edge after the last write, and stays 1 until reset.
- Request-to-grant latency is 1 cycle: `req` sampled at edge t gives `grant` and `alloc_addr` valid during cycle t+1.
- `grant`, `alloc_valid` and `alloc_addr` are registered and valid for one cycle per allocation.
- `free_cnt` and `rel_err` are registered and reflect every event up to the previous edge.
- Throughput: one allocation and one release per cycle, concurrently.

## Test plan
- **Init:** release reset, DEPTH=64 → `ready`=0 for 64 cycles, then `ready`=1 with `free_cnt`=64. No grant occurs even with `req`=0xFF held during INIT.
- **Single requester:** a one-cycle `req`=0x08 after `ready` → next cycle `grant`=0x08, `alloc_addr`=0, `free_cnt`=63. A second one-cycle pulse → `alloc_addr`=1.
- **Fairness and wrap:** `req`=0xFF held for 16 cycles → grants 0x01, 0x02, … 0x80, 0x01, … and `alloc_addr`=0..15.
  - Then `req`=0x81 with `rr_ptr`=0 → grants alternate 0x01, 0x80.
- **Exhaustion and simultaneous events:**
  - Allocate all 64 addresses → `free_cnt`=0 and no further grants.
  - Release 0x2A with `req`=0x01 in the same cycle → no grant that cycle. The next cycle `grant`=0x01 with `alloc_addr`=0x2A.
  - Alloc plus release in one cycle → `free_cnt` unchanged.
- **Overflow:** `rel_valid` with `free_cnt`=64 → `free_cnt` stays 64 and `rel_err`=1, which persists until `rst_n`=0.
- **Reset mid-operation:**
  - Assert `rst_n`=0 for 1 cycle at INIT cycle 30 → INIT restarts and `ready` rises 64 cycles after reset is released.
  - Assert reset in RUN with `free_cnt`=10 → INIT restarts and the pool ends at `free_cnt`=64 with `rel_err`=0.

Source files
------------

// File: rtl/sm_addr_alloc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sm_addr_alloc : shared-buffer free-address pool kept as a circular free list,
//                 granting one address per cycle to a round-robin winner port.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif

module sm_addr_alloc #(
  parameter int PORT_NUB_TOTAL = `PORT_NUB_TOTAL,
  parameter int DEPTH          = 64,
  parameter int ADDR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORT_NUB_TOTAL-1:0] req,
  output logic [PORT_NUB_TOTAL-1:0] grant,
  output logic                      alloc_valid,
  output logic [ADDR_WIDTH-1:0]     alloc_addr,
  input  logic                      rel_valid,
  input  logic [ADDR_WIDTH-1:0]     rel_addr,
  output logic                      ready,
  output logic [ADDR_WIDTH:0]       free_cnt,
  output logic                      rel_err
);

  localparam int PTR_W = (PORT_NUB_TOTAL > 1) ? $clog2(PORT_NUB_TOTAL) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]       CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]       CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]          PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]          PTR_LAST  = PTR_W'(PORT_NUB_TOTAL - 1);
  localparam logic [PORT_NUB_TOTAL-1:0] GRANT_ONE = PORT_NUB_TOTAL'(1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] list_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      scan_idx;
  logic                  win_found;
  logic                  do_alloc;
  logic                  rel_accept;
  logic                  rel_drop;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wdata;

  // First requesting port at or after rr_ptr, wrapping around the port range.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < PORT_NUB_TOTAL; k++) begin
      scan_idx = PTR_W'((32'(rr_ptr) + 32'(k)) % PORT_NUB_TOTAL);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign ready      = (state == ST_RUN);
  assign do_alloc   = ready && win_found && (free_cnt != '0);
  assign rel_accept = ready && rel_valid && (free_cnt != CNT_FULL);
  assign rel_drop   = ready && rel_valid && (free_cnt == CNT_FULL);

  // The tail pointer doubles as the fill counter while the list is seeded.
  assign mem_we    = rst_n && ((state == ST_INIT) || rel_accept);
  assign mem_wdata = (state == ST_INIT) ? tail : rel_addr;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      list_mem[tail] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      head        <= '0;
      tail        <= '0;
      free_cnt    <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      alloc_valid <= 1'b0;
      alloc_addr  <= '0;
      rel_err     <= 1'b0;
    end else begin
      grant       <= '0;
      alloc_valid <= 1'b0;
      alloc_addr  <= '0;
      case (state)
        ST_INIT: begin
          tail     <= tail + ADDR_ONE;
          free_cnt <= free_cnt + CNT_ONE;
          if (tail == ADDR_LAST) begin
            state <= ST_RUN;
          end
        end
        default: begin
          if (do_alloc) begin
            grant       <= GRANT_ONE << win_idx;
            alloc_valid <= 1'b1;
            alloc_addr  <= list_mem[head];
            head        <= head + ADDR_ONE;
            rr_ptr      <= (win_idx == PTR_LAST) ? '0 : win_idx + PTR_ONE;
          end
          if (rel_accept) begin
            tail <= tail + ADDR_ONE;
          end
          if (rel_drop) begin
            rel_err <= 1'b1;
          end
          case ({do_alloc, rel_accept})
            2'b10:   free_cnt <= free_cnt - CNT_ONE;
            2'b01:   free_cnt <= free_cnt + CNT_ONE;
            default: free_cnt <= free_cnt;
          endcase
        end
      endcase
    end
  end

endmodule

`default_nettype wire
